// File: rtl/colorfilter_px.sv
// colorfilter_px: 2-stage RGB dominance filter with per-frame pass counter.
// Define REJECT_GRAY_EN to output rejected pixels as grey instead of black.
module colorfilter_px #(
  parameter int C_W    = 4,
  parameter int ADDR_W = 17,
  parameter int THRESH = 2
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rgbmode,
  input  logic [2:0]        rgbfilter,
  input  logic [3*C_W-1:0]  px_in,
  input  logic              px_in_vld,
  input  logic [ADDR_W-1:0] px_in_addr,
  output logic [3*C_W-1:0]  px_out,
  output logic              px_out_vld,
  output logic [ADDR_W-1:0] px_out_addr,
  output logic [ADDR_W:0]   px_count,
  output logic              count_vld
);
  localparam int E_W = C_W + 2;
  logic [E_W-1:0] r, g, b, t;
  logic [2:0] dom, filt, s1_dom;
  logic [3*C_W-1:0] s1_px, rej;
  logic [ADDR_W-1:0] s1_addr;
  logic [ADDR_W:0] cnt;
  logic mode_rgb, s1_vld, fe_d, pass;
  assign r = E_W'(px_in[3*C_W-1 -: C_W]);
  assign g = E_W'(px_in[2*C_W-1 -: C_W]);
  assign b = E_W'(px_in[C_W-1:0]);
  assign t = E_W'(THRESH);
  assign dom = {r >= g + t && r >= b + t, g >= r + t && g >= b + t, b >= r + t && b >= g + t};
  // settings are frame-stable, so S2 can use the live registers directly
  assign pass = (filt == 3'b000) | ~mode_rgb | (|(filt & s1_dom));
`ifdef REJECT_GRAY_EN
  logic [E_W-1:0] y_sum;
  logic [C_W-1:0] s1_y;
  assign y_sum = r + (g << 1) + b;
  always_ff @(posedge clk or posedge rst)
    if (rst) s1_y <= '0;
    else s1_y <= y_sum[E_W-1:2];
  assign rej = {3{s1_y}};
`else
  assign rej = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt        <= 3'b000;
      mode_rgb    <= 1'b1;
      s1_px       <= '0;
      s1_addr     <= '0;
      s1_vld      <= 1'b0;
      s1_dom      <= '0;
      px_out      <= '0;
      px_out_addr <= '0;
      px_out_vld  <= 1'b0;
      fe_d        <= 1'b0;
      count_vld   <= 1'b0;
      px_count    <= '0;
      cnt         <= '0;
    end else begin
      if (frame_start) begin
        filt     <= rgbfilter;
        mode_rgb <= rgbmode;
      end
      s1_px       <= px_in;
      s1_addr     <= px_in_addr;
      s1_vld      <= px_in_vld;
      s1_dom      <= dom;
      px_out      <= pass ? s1_px : rej;
      px_out_addr <= s1_addr;
      px_out_vld  <= s1_vld;
      fe_d        <= frame_end;
      count_vld   <= fe_d;
      if (fe_d) px_count <= cnt;
      cnt <= frame_start ? '0 : (s1_vld && pass && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_colorfilter_px.sv
// tb_colorfilter_px: scoreboard bench with directed pixel/frame vectors.
module tb_colorfilter_px;
  localparam int AW = 4;
  logic rst, clk, frame_start, frame_end, rgbmode, px_in_vld, px_out_vld, count_vld;
  logic [2:0] rgbfilter;
  logic [11:0] px_in, px_out;
  logic [AW-1:0] px_in_addr, px_out_addr, addr;
  logic [AW:0] px_count;
  int cyc, total, passed;
  typedef struct {logic [11:0] px; logic [AW-1:0] a; int c;} pexp_t;
  typedef struct {logic [AW:0] n; int c;} cexp_t;
  pexp_t pq[$];
  cexp_t cq[$];

  colorfilter_px #(.C_W(4), .ADDR_W(AW), .THRESH(2)) dut (
    .rst(rst), .clk(clk), .frame_start(frame_start), .frame_end(frame_end),
    .rgbmode(rgbmode), .rgbfilter(rgbfilter), .px_in(px_in), .px_in_vld(px_in_vld),
    .px_in_addr(px_in_addr), .px_out(px_out), .px_out_vld(px_out_vld),
    .px_out_addr(px_out_addr), .px_count(px_count), .count_vld(count_vld)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
  endtask

  always @(negedge clk) if (!rst) begin
    if (px_out_vld) begin
      if (pq.size() == 0) begin
        total++;
        $display("FAIL px_unexpected: got px %03h with no expected pixel", px_out);
      end else begin
        pexp_t e;
        e = pq.pop_front();
        chk("px_out", 32'(px_out), 32'(e.px));
        chk("px_addr", 32'(px_out_addr), 32'(e.a));
        chk("px_latency", cyc, e.c);
      end
    end
    if (count_vld) begin
      if (cq.size() == 0) begin
        total++;
        $display("FAIL cnt_unexpected: got count %0d with no expected update", px_count);
      end else begin
        cexp_t e;
        e = cq.pop_front();
        chk("px_count", 32'(px_count), 32'(e.n));
        chk("cnt_latency", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    px_in_vld = 0;
    frame_start = 0;
    frame_end = 0;
  endtask

  task automatic fs(input logic [2:0] f, input logic m);
    frame_start = 1;
    rgbfilter = f;
    rgbmode = m;
  endtask

  // ok: pixel expected to pass; gray: hand-computed grey for a rejected pixel
  task automatic pix(input logic [11:0] p, input logic ok, input logic [11:0] gray);
    logic [11:0] rej;
`ifdef REJECT_GRAY_EN
    rej = gray;
`else
    rej = 12'h000;
`endif
    px_in = p;
    px_in_vld = 1;
    px_in_addr = addr;
    pq.push_back('{ok ? p : rej, addr, cyc + 2});
    addr++;
    step();
  endtask

  task automatic fe(input logic [AW:0] n);
    frame_end = 1;
    cq.push_back('{n, cyc + 2});
    step();
  endtask

  initial begin
    cyc = 0; total = 0; passed = 0; addr = 0;
    rst = 1; frame_start = 0; frame_end = 0; rgbmode = 1; rgbfilter = 0;
    px_in = 0; px_in_vld = 0; px_in_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_px_out", 32'(px_out), 0);
    chk("rst_px_vld", 32'(px_out_vld), 0);
    chk("rst_addr", 32'(px_out_addr), 0);
    chk("rst_count", 32'(px_count), 0);
    chk("rst_count_vld", 32'(count_vld), 0);
    rst = 0;
    pix(12'hF00, 1, 12'h000);
    fs(3'b100, 1);
    pix(12'hF21, 1, 12'h000);
    pix(12'h8A2, 0, 12'h777);
    pix(12'h442, 0, 12'h333);
    fs(3'b011, 1);
    pix(12'h2F0, 1, 12'h000);
    pix(12'h13F, 1, 12'h000);
    pix(12'h530, 0, 12'h222);
    pix(12'h350, 1, 12'h000);
    pix(12'h450, 0, 12'h333);
    fs(3'b100, 1);
    pix(12'h0F0, 0, 12'h777);
    rgbfilter = 3'b010;
    pix(12'h0F0, 0, 12'h777);
    fs(3'b010, 1);
    pix(12'h0F0, 1, 12'h000);
    fs(3'b111, 0);
    pix(12'h777, 1, 12'h000);
    pix(12'h530, 1, 12'h000);
    fs(3'b100, 1);
    pix(12'hF00, 1, 12'h000);
    pix(12'hF21, 1, 12'h000);
    pix(12'h8A2, 0, 12'h777);
    pix(12'hA00, 1, 12'h000);
    pix(12'h442, 0, 12'h333);
    pix(12'h900, 1, 12'h000);
    pix(12'h0F0, 0, 12'h777);
    pix(12'h622, 1, 12'h000);
    fe(5);
    step();
    fs(3'b100, 1);
    pix(12'hF00, 1, 12'h000);
    pix(12'hF00, 1, 12'h000);
    fe(2);
    fs(3'b100, 1);
    pix(12'hF00, 1, 12'h000);
    fe(1);
    step();
    fe(1);
    fs(3'b000, 1);
    for (int i = 0; i < 40; i++) pix(12'h0F0, 1, 12'h000);
    fe(31);
    repeat (3) step();
    fs(3'b100, 1);
    step();
    px_in = 12'h0F0; px_in_vld = 1; px_in_addr = addr;
    step();
    rst = 1;
    #2;
    chk("midrst_px_vld", 32'(px_out_vld), 0);
    chk("midrst_px_out", 32'(px_out), 0);
    @(posedge clk);
    #1;
    rst = 0;
    pix(12'h0F0, 1, 12'h000);
    for (int i = 0; i < 20 && (pq.size() + cq.size()) != 0; i++) step();
    chk("drain", pq.size() + cq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
